poly_player: RTL and testbench

Polyphonic successor to the single-voice tone player. It accepts the same 8-bit keyboard note messages and allocates them across `VOICES` independent square-wave oscillators. Active voices are mixed through a first-order sigma-delta modulator into one 1-bit `wave` output, which drives the buzzer/speaker mux in the top level. It runs entirely in the PLL clock domain; the integrator synchronises `msg_valid` from the keyboard domain.

---
 rtl/poly_pkg.sv | 49 ++++
 rtl/tone_voice.sv | 50 +++++
 rtl/poly_player.sv | 186 ++++++++++++++++++
 tb/tb_poly_player.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/poly_pkg.sv
// poly_pkg: shared definitions for the polyphonic tone player.
//   - F4_MHZ       : octave-4 semitone frequencies in mHz (C4 .. B4)
//   - MSG_*        : field positions inside the 8-bit keyboard message
//   - voice_t      : per-voice record (held note, age, active flag)
//   - half_period(): elaboration-time half-period count for a note id
package poly_pkg;

    localparam int MSG_ON_BIT = 7;
    localparam int MSG_ID_MSB = 6;
    localparam int MSG_ID_LSB = 0;
    localparam int MSG_ID_W   = MSG_ID_MSB - MSG_ID_LSB + 1;
    localparam int AGE_W      = 3;

    localparam longint F4_MHZ [12] = '{
        261626, 277183, 293665, 311127, 329628, 349228,
        369994, 391995, 415305, 440000, 466164, 493883
    };

    typedef struct packed {
        logic [MSG_ID_W-1:0] note;
        logic [AGE_W-1:0]    age;
        logic                active;
    } voice_t;

    // Half-period in clock cycles for note id (1 = C3). Ids that cannot be
    // held by a voice still return a non-zero count so the table is safe.
    function automatic longint half_period(input longint clk_freq, input int id);
        int     semi;
        int     oct;
        longint base;
        longint hp;
        if (id < 1) begin
            return 64'sd1;
        end
        semi = (id - 1) % 12;
        oct  = 3 + (id - 1) / 12;
        base = (clk_freq * 1000) / (2 * F4_MHZ[semi]);
        if (oct <= 4) begin
            hp = base << (4 - oct);
        end else begin
            hp = base >> (oct - 4);
        end
        if (hp < 1) begin
            hp = 1;
        end
        return hp;
    endfunction

endpackage

// File: rtl/tone_voice.sv
// tone_voice: one square-wave oscillator.
//   clk, rst    : clock and synchronous active-high reset
//   run_i       : voice will be active next cycle; low forces counter/phase to 0
//   restart_i   : (re)allocation this cycle; counter and phase restart at 0
//   hp_i        : half-period count for the currently held note
//   phase_o     : registered square-wave phase (0 whenever the voice is idle)
module tone_voice
    import poly_pkg::*;
#(
    parameter int CW = 19
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          run_i,
    input  logic          restart_i,
    input  logic [CW-1:0] hp_i,
    output logic          phase_o
);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          phase_q, phase_d;

    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (!run_i || restart_i) begin
            // Freeing clears the phase on the same edge, so no residual high.
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (cnt_q == hp_i - CW'(1)) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign phase_o = phase_q;

endmodule

// File: rtl/poly_player.sv
// poly_player: polyphonic square-wave player with sigma-delta mixing.
//   clk, rst   : clock and synchronous active-high reset
//   msg_valid  : one-cycle strobe qualifying msg
//   msg        : bit7 note-on/off, bits 6:0 note id (0 on note-off = all off)
//   wave       : 1-bit sigma-delta mix of all active voices
//   active     : bit i set while voice i holds a note
//   drop       : one-cycle pulse when a note-on finds no free voice
// Build option: define POLY_STEAL_EN to steal the oldest voice instead of
// dropping a note-on when all voices are busy.
module poly_player
    import poly_pkg::*;
#(
    parameter int CLK_FREQ = 120_000_000,
    parameter int VOICES   = 4,
    parameter int NOTES    = 48
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              msg_valid,
    input  logic [7:0]        msg,
    output logic              wave,
    output logic [VOICES-1:0] active,
    output logic              drop
);

    localparam int CW = $clog2(half_period(longint'(CLK_FREQ), 1) + 1);
    localparam int AW = $clog2(VOICES) + 1;
    localparam int IW = (VOICES > 1) ? $clog2(VOICES) : 1;
    localparam logic [AGE_W-1:0]    AGE_MAX  = AGE_W'(VOICES - 1);
    localparam logic [MSG_ID_W-1:0] NOTES_ID = MSG_ID_W'(NOTES);
    localparam logic [AW:0]         VOICES_T = (AW + 1)'(VOICES);

    // Half-period lookup indexed by note id; ids outside 1..NOTES are never held.
    logic [CW-1:0] hp_tab [128];
    for (genvar gi = 0; gi < 128; gi++) begin : g_hp
        localparam longint HPV = ((gi >= 1) && (gi <= NOTES))
                                 ? half_period(longint'(CLK_FREQ), gi) : 64'sd1;
        assign hp_tab[gi] = CW'(HPV);
    end

    voice_t voice_q [VOICES];
    voice_t voice_d [VOICES];
    logic [VOICES-1:0] restart;
    logic [VOICES-1:0] phase;
    logic              drop_q, drop_d;
    logic              wave_q, wave_d;
    logic [AW-1:0]     acc_q, acc_d;

    logic [MSG_ID_W-1:0] msg_id;
    logic                is_on;
    logic                legal;
    logic                hit_any, free_any, trig;
    logic [IW-1:0]       hit_idx, free_idx, tgt;

    assign msg_id = msg[MSG_ID_MSB:MSG_ID_LSB];
    assign is_on  = msg[MSG_ON_BIT];
    assign legal  = (msg_id != '0) && (msg_id <= NOTES_ID);

    // Descending scan so the lowest matching index wins.
    always_comb begin
        hit_any  = 1'b0;
        hit_idx  = '0;
        free_any = 1'b0;
        free_idx = '0;
        for (int i = VOICES - 1; i >= 0; i--) begin
            if (voice_q[i].active && (voice_q[i].note == msg_id)) begin
                hit_any = 1'b1;
                hit_idx = IW'(i);
            end
            if (!voice_q[i].active) begin
                free_any = 1'b1;
                free_idx = IW'(i);
            end
        end
    end

`ifdef POLY_STEAL_EN
    // Oldest voice; strict '>' keeps the lowest index on ties.
    logic [IW-1:0] old_idx;
    always_comb begin
        old_idx = '0;
        for (int i = 1; i < VOICES; i++) begin
            if (voice_q[i].age > voice_q[old_idx].age) begin
                old_idx = IW'(i);
            end
        end
    end
`endif

    always_comb begin
        trig   = 1'b0;
        tgt    = '0;
        drop_d = 1'b0;
        if (msg_valid && is_on && legal) begin
            if (hit_any) begin
                trig = 1'b1;
                tgt  = hit_idx;
            end else if (free_any) begin
                trig = 1'b1;
                tgt  = free_idx;
            end else begin
`ifdef POLY_STEAL_EN
                trig = 1'b1;
                tgt  = old_idx;
`else
                drop_d = 1'b1;
`endif
            end
        end
    end

    always_comb begin
        restart = '0;
        for (int i = 0; i < VOICES; i++) begin
            voice_d[i] = voice_q[i];
        end
        if (trig) begin
            for (int i = 0; i < VOICES; i++) begin
                if (IW'(i) == tgt) begin
                    voice_d[i] = '{note: msg_id, age: '0, active: 1'b1};
                    restart[i] = 1'b1;
                end else if (voice_q[i].active && (voice_q[i].age != AGE_MAX)) begin
                    voice_d[i].age = voice_q[i].age + AGE_W'(1);
                end
            end
        end else if (msg_valid && !is_on) begin
            for (int i = 0; i < VOICES; i++) begin
                if ((msg_id == '0) || (voice_q[i].active && (voice_q[i].note == msg_id))) begin
                    voice_d[i] = '0;
                end
            end
        end
    end

    for (genvar gi = 0; gi < VOICES; gi++) begin : g_voice
        tone_voice #(.CW(CW)) u_voice (
            .clk       (clk),
            .rst       (rst),
            .run_i     (voice_d[gi].active),
            .restart_i (restart[gi]),
            .hp_i      (hp_tab[voice_q[gi].note]),
            .phase_o   (phase[gi])
        );
        assign active[gi] = voice_q[gi].active;
    end

    // First-order sigma-delta: carry out of a modulo-VOICES accumulator.
    logic [AW-1:0] sum;
    logic [AW:0]   t;
    always_comb begin
        sum = '0;
        for (int i = 0; i < VOICES; i++) begin
            sum = sum + AW'(phase[i]);
        end
        t = {1'b0, acc_q} + {1'b0, sum};
        if (t >= VOICES_T) begin
            acc_d  = AW'(t - VOICES_T);
            wave_d = 1'b1;
        end else begin
            acc_d  = AW'(t);
            wave_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < VOICES; i++) begin
                voice_q[i] <= '0;
            end
            acc_q  <= '0;
            wave_q <= 1'b0;
            drop_q <= 1'b0;
        end else begin
            for (int i = 0; i < VOICES; i++) begin
                voice_q[i] <= voice_d[i];
            end
            acc_q  <= acc_d;
            wave_q <= wave_d;
            drop_q <= drop_d;
        end
    end

    assign wave = wave_q;
    assign drop = drop_q;

endmodule

// File: tb/tb_poly_player.sv
// Self-checking bench for poly_player. A small clock frequency keeps the
// oscillator periods short. The reference model tracks each voice as
// (note, age, start edge) and derives its phase from elapsed cycles.
module tb_poly_player;

    localparam int CLK_FREQ = 100_000;
    localparam int V        = 4;
    localparam int N        = 48;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         msg_valid = 1'b0;
    logic [7:0]   msg = 8'h00;
    logic         wave;
    logic [V-1:0] active;
    logic         drop;

    poly_player #(.CLK_FREQ(CLK_FREQ), .VOICES(V), .NOTES(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .msg_valid (msg_valid),
        .msg       (msg),
        .wave      (wave),
        .active    (active),
        .drop      (drop)
    );

    always #5 clk = ~clk;

    localparam longint F4 [12] = '{
        261626, 277183, 293665, 311127, 329628, 349228,
        369994, 391995, 415305, 440000, 466164, 493883
    };

    int     vectors = 0;
    int     miscompares = 0;
    longint cyc = 0;

    int     m_note  [V];
    int     m_age   [V];
    bit     m_act   [V];
    longint m_start [V];
    int     m_acc = 0;
    bit     m_wave = 0;
    bit     m_drop = 0;

    function automatic longint hp_of(input int id);
        int     semi;
        int     oct;
        longint base;
        semi = (id - 1) % 12;
        oct  = 3 + (id - 1) / 12;
        base = (longint'(CLK_FREQ) * 1000) / (2 * F4[semi]);
        return (oct <= 4) ? (base << (4 - oct)) : (base >> (oct - 4));
    endfunction

    task automatic model_clear();
        for (int i = 0; i < V; i++) begin
            m_note[i] = 0; m_age[i] = 0; m_act[i] = 0; m_start[i] = 0;
        end
    endtask

    task automatic model_msg(input logic [7:0] m);
        int id;
        int tg;
        id = int'(m[6:0]);
        tg = -1;
        if (m[7]) begin
            if (id < 1 || id > N) return;
            for (int i = 0; i < V; i++) if (tg < 0 && m_act[i] && m_note[i] == id) tg = i;
            if (tg < 0) for (int i = 0; i < V; i++) if (tg < 0 && !m_act[i]) tg = i;
            if (tg < 0) begin
`ifdef POLY_STEAL_EN
                tg = 0;
                for (int i = 1; i < V; i++) if (m_age[i] > m_age[tg]) tg = i;
`else
                m_drop = 1;
                return;
`endif
            end
            for (int i = 0; i < V; i++)
                if (i != tg && m_act[i] && m_age[i] < V - 1) m_age[i]++;
            m_note[tg] = id; m_age[tg] = 0; m_act[tg] = 1; m_start[tg] = cyc;
        end else begin
            for (int i = 0; i < V; i++) begin
                if (id == 0 || (m_act[i] && m_note[i] == id)) begin
                    m_note[i] = 0; m_age[i] = 0; m_act[i] = 0;
                end
            end
        end
    endtask

    // One clock: drive inputs, advance the model across the edge, compare.
    task automatic step(input bit r, input bit v, input logic [7:0] m);
        int             sum;
        logic [V-1:0]   exp_act;
        rst = r; msg_valid = v; msg = m;
        @(posedge clk);
        sum = 0;
        for (int i = 0; i < V; i++)
            if (m_act[i] && (((cyc - m_start[i]) / hp_of(m_note[i])) % 2 == 1)) sum++;
        cyc++;
        m_drop = 0;
        if (r) begin
            model_clear();
            m_acc = 0; m_wave = 0;
        end else begin
            m_acc = m_acc + sum;
            if (m_acc >= V) begin m_acc -= V; m_wave = 1; end
            else m_wave = 0;
            if (v) model_msg(m);
        end
        for (int i = 0; i < V; i++) exp_act[i] = m_act[i];
        #1;
        vectors++;
        assert (wave === m_wave) else begin
            miscompares++;
            $error("FAIL wave cyc=%0d observed=%b expected=%b", cyc, wave, m_wave);
        end
        vectors++;
        assert (active === exp_act) else begin
            miscompares++;
            $error("FAIL active cyc=%0d observed=%b expected=%b", cyc, active, exp_act);
        end
        vectors++;
        assert (drop === m_drop) else begin
            miscompares++;
            $error("FAIL drop cyc=%0d observed=%b expected=%b", cyc, drop, m_drop);
        end
        rst = 0; msg_valid = 0; msg = 8'h00;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 8'h00);
    endtask

    function automatic logic [7:0] on_msg(input int id);
        return {1'b1, 7'(id)};
    endfunction

    function automatic logic [7:0] off_msg(input int id);
        return {1'b0, 7'(id)};
    endfunction

    initial begin
        model_clear();
        // Reset state
        step(1, 0, 8'h00);
        step(1, 0, 8'h00);
        // Single note A3, several phase periods
        step(0, 1, on_msg(10));
        idle(600);
        // Allocation order and note-off of a middle voice
        step(0, 1, off_msg(0));
        step(0, 1, on_msg(1));
        step(0, 1, on_msg(5));
        step(0, 1, on_msg(8));
        step(0, 1, off_msg(5));
        idle(300);
        // Retrigger of a held note
        step(0, 1, on_msg(1));
        idle(400);
        // Full: steal or drop
        step(0, 1, off_msg(0));
        step(0, 1, on_msg(1));
        step(0, 1, on_msg(2));
        step(0, 1, on_msg(3));
        step(0, 1, on_msg(4));
        idle(30);
        step(0, 1, on_msg(5));
        idle(400);
        // Illegal ids, then all-notes-off and drain
        step(0, 1, on_msg(0));
        step(0, 1, on_msg(49));
        step(0, 1, off_msg(0));
        idle(20);
        // Reset with a simultaneous message
        step(0, 1, on_msg(12));
        step(0, 1, on_msg(24));
        step(0, 1, on_msg(36));
        idle(100);
        step(1, 1, on_msg(48));
        idle(5);
        // Randomized traffic, including back-to-back messages
        for (int k = 0; k < 4000; k++) begin
            bit          r;
            bit          v;
            int          id;
            logic [7:0]  m;
            r  = ($urandom_range(0, 999) == 0);
            v  = ($urandom_range(0, 5) == 0);
            id = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 127))
                                             : int'($urandom_range(0, 9));
            if (id == 0 && $urandom_range(0, 3) != 0) id = 1;
            m = {1'($urandom_range(0, 2) != 0), 7'(id)};
            step(r, v, m);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
